// File: rtl/dmem_wait_model.sv
// Word-addressed data memory with byte-lane stores, a req/ready/rvalid handshake and programmable wait states.
// Optional out-of-range checking is enabled by defining DM_ERR_EN; by default the index wraps modulo DEPTH.
module dmem_wait_model #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        cm_valid,
  output logic [31:0] cm_pc,
  output logic [31:0] cm_addr,
  output logic [31:0] cm_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // BUSY lasts LATENCY-1 cycles; the counter starts at 0 on acceptance.
  localparam logic [3:0] LAST_CNT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

`ifdef DM_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] idx_full;
  logic [AW-1:0] word_idx;
  logic        oob;
  logic [31:0] old_word;
  logic [31:0] merged;
  logic        in_resp;
  logic        wr_en;

  always_comb begin
    idx_full = (addr_q - BASE_ADDR) >> 2;
    word_idx = idx_full[AW-1:0];
    oob      = ERR_EN & (idx_full >= 32'(DEPTH));
    old_word = mem_q[word_idx];
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : old_word[8*i +: 8];
    end
    in_resp  = (state_q == S_RESP);
    wr_en    = in_resp && (be_q != 4'b0000) && !oob;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          be_d    = byteen;
          wdata_d = wdata;
          pc_d    = pc;
          cnt_d   = 4'd0;
          state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
    end
  end

  // Storage is cleared with the rest of the state so every run starts from a known image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (wr_en) begin
      mem_q[word_idx] <= merged;
    end
  end

  always_comb begin
    ready    = (state_q == S_IDLE);
    rvalid   = in_resp;
    err      = in_resp && oob;
    rdata    = (in_resp && !oob) ? merged : 32'd0;
    cm_valid = wr_en;
    cm_pc    = wr_en ? pc_q : 32'd0;
    cm_addr  = wr_en ? (addr_q & ~32'd3) : 32'd0;
    cm_data  = wr_en ? merged : 32'd0;
  end

endmodule
